spi_slave_byte: RTL

//  SPI responder (slave) mirroring spi_master_byte, for loopback benches and for FPGA-as-peripheral links.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_slave_sync.sv | 53 +++++
 rtl/spi_slave_byte.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encodings, byte width and the responder state enum.
package spi_pkg;

  localparam int BYTE_W = 8;

  // Mode encodings are {CPOL, CPHA}.
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  typedef enum logic [1:0] {
    ST_WAIT_IDLE,
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT
  } slave_state_t;

endpackage

// File: rtl/spi_slave_sync.sv
// Synchronizes sclk/n_cs/mosi into sys_clk and produces single-cycle lead/trail
// and chip-select edge strobes.
module spi_slave_sync #(
  parameter bit CPOL        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic sclk,
  input  logic n_cs,
  input  logic mosi,
  output logic lead,
  output logic trail,
  output logic cs_fall,
  output logic cs_rise,
  output logic n_cs_sync,
  output logic mosi_sync
);

  logic [SYNC_STAGES-1:0] sclk_pipe;
  logic [SYNC_STAGES-1:0] n_cs_pipe;
  logic [SYNC_STAGES-1:0] mosi_pipe;
  logic                   sclk_prev;
  logic                   n_cs_prev;
  logic                   sclk_sync;

  // n_cs resets to "selected" so a frame already in progress is never seen as a fresh fall.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sclk_pipe <= {SYNC_STAGES{CPOL}};
      n_cs_pipe <= '0;
      mosi_pipe <= '0;
      sclk_prev <= CPOL;
      n_cs_prev <= 1'b0;
    end else begin
      sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], sclk};
      n_cs_pipe <= {n_cs_pipe[SYNC_STAGES-2:0], n_cs};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_pipe[SYNC_STAGES-1];
      n_cs_prev <= n_cs_pipe[SYNC_STAGES-1];
    end
  end

  assign sclk_sync = sclk_pipe[SYNC_STAGES-1];
  assign n_cs_sync = n_cs_pipe[SYNC_STAGES-1];
  assign mosi_sync = mosi_pipe[SYNC_STAGES-1];

  assign lead    = (sclk_sync != CPOL) && (sclk_prev == CPOL);
  assign trail   = (sclk_sync == CPOL) && (sclk_prev != CPOL);
  assign cs_fall = !n_cs_sync && n_cs_prev;
  assign cs_rise = n_cs_sync && !n_cs_prev;

endmodule

// File: rtl/spi_slave_byte.sv
// SPI responder: MSB-first byte shifter with rx FIFO push and show-ahead tx FIFO pop.
// Optional frame checking is enabled by defining SPI_SLAVE_FRAME_ERR_EN.
module spi_slave_byte
  import spi_pkg::*;
#(
  parameter bit               CPOL            = 1'b0,
  parameter bit               CPHA            = 1'b0,
  parameter int               BYTES_PER_FRAME = 2,
  parameter int               SYNC_STAGES     = 2,
  parameter logic [BYTE_W-1:0] TX_FILL        = 8'h00
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              n_cs,
  input  logic              mosi,
  output logic              miso,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_empty,
  output logic              tx_rdreq,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_wrreq,
  output logic              busy,
  output logic              frame_err
);

  slave_state_t      state;
  logic [BYTE_W-1:0] shift_in;
  logic [BYTE_W-1:0] shift_out;
  logic [2:0]        bit_cnt;
  logic              load_pending;
  logic              lead, trail, cs_fall, cs_rise, n_cs_sync, mosi_sync;
  logic              sample_edge, shift_edge;
  logic [BYTE_W-1:0] next_byte;

  spi_slave_sync #(
    .CPOL        (CPOL),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .sclk      (sclk),
    .n_cs      (n_cs),
    .mosi      (mosi),
    .lead      (lead),
    .trail     (trail),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .n_cs_sync (n_cs_sync),
    .mosi_sync (mosi_sync)
  );

  assign sample_edge = CPHA ? trail : lead;
  assign shift_edge  = CPHA ? lead : trail;
  assign next_byte   = tx_empty ? TX_FILL : tx_data;

  // shift_out always holds the bits still to be driven, so both phases shift identically.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state        <= ST_WAIT_IDLE;
      miso         <= 1'b0;
      tx_rdreq     <= 1'b0;
      rx_data      <= '0;
      rx_wrreq     <= 1'b0;
      busy         <= 1'b0;
      shift_in     <= '0;
      shift_out    <= '0;
      bit_cnt      <= '0;
      load_pending <= 1'b0;
    end else begin
      tx_rdreq <= 1'b0;
      rx_wrreq <= 1'b0;
      case (state)
        ST_WAIT_IDLE: begin
          miso <= 1'b0;
          if (n_cs_sync) state <= ST_IDLE;
        end
        ST_IDLE: begin
          miso <= 1'b0;
          if (cs_fall) begin
            state        <= ST_LOAD;
            busy         <= 1'b1;
            bit_cnt      <= '0;
            load_pending <= 1'b0;
          end
        end
        ST_LOAD: begin
          state    <= ST_SHIFT;
          tx_rdreq <= !tx_empty;
          if (CPHA) begin
            shift_out <= next_byte;
          end else begin
            miso      <= next_byte[BYTE_W-1];
            shift_out <= {next_byte[BYTE_W-2:0], 1'b0};
          end
        end
        ST_SHIFT: begin
          if (cs_rise) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            miso  <= 1'b0;
          end else if (sample_edge) begin
            shift_in <= {shift_in[BYTE_W-2:0], mosi_sync};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data      <= {shift_in[BYTE_W-2:0], mosi_sync};
              rx_wrreq     <= 1'b1;
              load_pending <= 1'b1;
            end
          end else if (shift_edge) begin
            if (load_pending) begin
              miso         <= next_byte[BYTE_W-1];
              shift_out    <= {next_byte[BYTE_W-2:0], 1'b0};
              tx_rdreq     <= !tx_empty;
              load_pending <= 1'b0;
            end else begin
              miso      <= shift_out[BYTE_W-1];
              shift_out <= {shift_out[BYTE_W-2:0], 1'b0};
            end
          end
        end
        default: state <= ST_WAIT_IDLE;
      endcase
    end
  end

`ifdef SPI_SLAVE_FRAME_ERR_EN
  localparam logic [7:0] FRAME_BYTES = BYTES_PER_FRAME[7:0];

  logic [7:0] byte_cnt;

  // Completed bytes per frame, saturating; judged against FRAME_BYTES when n_cs releases.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      byte_cnt  <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (state == ST_IDLE && cs_fall) begin
        byte_cnt <= '0;
      end else if (state == ST_SHIFT && !cs_rise && sample_edge &&
                   bit_cnt == 3'd7 && byte_cnt != 8'hFF) begin
        byte_cnt <= byte_cnt + 8'd1;
      end
      if (state == ST_SHIFT && cs_rise) begin
        frame_err <= (bit_cnt != 3'd0) || (byte_cnt != FRAME_BYTES);
      end
    end
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule
